// File: rtl/kbd_seg_ctrl.sv
// ---------------------------------------------------------------------------
// kbd_seg_ctrl
//   Sequencing controller for the six-digit seven-segment display path.
//   Accepts PS/2 key events over a valid/ready handshake, latches the scan
//   code and ASCII value, counts distinct key presses in BCD and drives a
//   single display enable that stays on while a key is held and for
//   HOLD_CYCLES clocks after its release.
//
//   Ports
//     clk         system clock, rising edge
//     rst         synchronous active-high reset
//     evt_valid   key event present
//     evt_ready   controller can accept an event this cycle (registered)
//     evt_code    PS/2 make code
//     evt_break   1 = release event, 0 = press event
//     evt_ascii   ASCII for evt_code (used on make events only)
//     cnt_clr     synchronous clear of the press counter
//     disp_code   latched scan code   (digits 0-1)
//     disp_ascii  latched ASCII       (digits 2-3)
//     disp_count  BCD press count     (digits 4-5), [7:4] tens, [3:0] units
//     disp_en     display enable
// ---------------------------------------------------------------------------
module kbd_seg_ctrl #(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned TMR_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       evt_valid,
  output logic       evt_ready,
  input  logic [7:0] evt_code,
  input  logic       evt_break,
  input  logic [7:0] evt_ascii,
  input  logic       cnt_clr,
  output logic [7:0] disp_code,
  output logic [7:0] disp_ascii,
  output logic [7:0] disp_count,
  output logic       disp_en
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_HOLD
  } state_e;

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       ascii_q, ascii_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       held_q, held_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic accept;
  logic same_key;

  // Two-digit BCD increment; 99 wraps to 00, nibbles never exceed 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  assign accept   = evt_valid & ready_q;
  assign same_key = (evt_code == held_q);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ascii_d = ascii_q;
    count_d = count_q;
    held_d  = held_q;
    tmr_d   = tmr_q;
    // Ready drops for exactly one cycle after each accept.
    ready_d = ~accept;

    // Hold countdown; an event below may override it.
    if (state_q == S_HOLD) begin
      tmr_d = tmr_q - TMR_ONE;
      if (tmr_q <= TMR_ONE) begin
        state_d = S_IDLE;
      end
    end

    if (accept) begin
      if (!evt_break) begin
        // Typematic repeat of the held key is swallowed.
        if (state_q != S_SHOW || !same_key) begin
          code_d  = evt_code;
          ascii_d = evt_ascii;
          held_d  = evt_code;
          count_d = bcd_inc(count_q);
          tmr_d   = '0;
          state_d = S_SHOW;
        end
      end else if (state_q == S_SHOW && same_key) begin
        if (HOLD_CYCLES == 0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d   = HOLD_LOAD;
          state_d = S_HOLD;
        end
      end
    end

    if (cnt_clr) begin
      count_d = '0;
    end

    en_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      en_q    <= 1'b0;
      code_q  <= '0;
      ascii_q <= '0;
      count_q <= '0;
      held_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      code_q  <= code_d;
      ascii_q <= ascii_d;
      count_q <= count_d;
      held_q  <= held_d;
      tmr_q   <= tmr_d;
    end
  end

  assign evt_ready  = ready_q;
  assign disp_en    = en_q;
  assign disp_code  = code_q;
  assign disp_ascii = ascii_q;
  assign disp_count = count_q;

endmodule

// File: tb/tb_kbd_seg_ctrl.sv
module tb_kbd_seg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, evt_valid, evt_break, cnt_clr;
  logic [7:0] evt_code, evt_ascii;

  logic       rdy4, en4, rdy0, en0;
  logic [7:0] code4, asc4, cnt4, code0, asc0, cnt0;

  kbd_seg_ctrl #(.HOLD_CYCLES(4), .TMR_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .evt_valid(evt_valid), .evt_ready(rdy4),
    .evt_code(evt_code), .evt_break(evt_break), .evt_ascii(evt_ascii),
    .cnt_clr(cnt_clr), .disp_code(code4), .disp_ascii(asc4),
    .disp_count(cnt4), .disp_en(en4)
  );

  kbd_seg_ctrl #(.HOLD_CYCLES(0), .TMR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .evt_valid(evt_valid), .evt_ready(rdy0),
    .evt_code(evt_code), .evt_break(evt_break), .evt_ascii(evt_ascii),
    .cnt_clr(cnt_clr), .disp_code(code0), .disp_ascii(asc0),
    .disp_count(cnt0), .disp_en(en0)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: key held flag, remaining lit cycles after release,
  // integer press count. Index 0 models HOLD=4, index 1 models HOLD=0.
  int         m_hold[2] = '{4, 0};
  bit         m_down[2];
  logic [7:0] m_held[2], m_code[2], m_asc[2];
  int         m_cnt[2], m_remain[2];
  bit         m_rdy[2];

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic model_step();
    bit acc;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_down[k] = 0; m_held[k] = 8'h00; m_code[k] = 8'h00; m_asc[k] = 8'h00;
        m_cnt[k] = 0; m_remain[k] = 0; m_rdy[k] = 1;
      end else begin
        acc = evt_valid && m_rdy[k];
        m_rdy[k] = !acc;
        if (!m_down[k] && m_remain[k] > 0) m_remain[k]--;
        if (acc) begin
          if (!evt_break) begin
            if (!m_down[k] || evt_code != m_held[k]) begin
              m_down[k] = 1; m_remain[k] = 0;
              m_held[k] = evt_code; m_code[k] = evt_code; m_asc[k] = evt_ascii;
              if (!cnt_clr) m_cnt[k] = (m_cnt[k] + 1) % 100;
            end
          end else if (m_down[k] && evt_code == m_held[k]) begin
            m_down[k] = 0;
            m_remain[k] = m_hold[k];
          end
        end
        if (cnt_clr) m_cnt[k] = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit v, input bit b, input logic [7:0] c,
                       input logic [7:0] a, input bit clr);
    rst = r; evt_valid = v; evt_break = b; evt_code = c; evt_ascii = a; cnt_clr = clr;
  endtask

  task automatic check_model();
    check("rnd en4",   en4,   8'(m_down[0] || m_remain[0] > 0));
    check("rnd rdy4",  rdy4,  8'(m_rdy[0]));
    check("rnd code4", code4, m_code[0]);
    check("rnd asc4",  asc4,  m_asc[0]);
    check("rnd cnt4",  cnt4,  to_bcd(m_cnt[0]));
    check("rnd en0",   en0,   8'(m_down[1] || m_remain[1] > 0));
    check("rnd rdy0",  rdy0,  8'(m_rdy[1]));
    check("rnd code0", code0, m_code[1]);
    check("rnd asc0",  asc0,  m_asc[1]);
    check("rnd cnt0",  cnt0,  to_bcd(m_cnt[1]));
  endtask

  typedef struct {
    bit         r, v, b;
    logic [7:0] code, asc;
    bit         clr;
    bit         e_en;
    logic [7:0] e_code, e_asc, e_cnt;
    bit         e_rdy;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit v, input bit b, input logic [7:0] c,
                     input logic [7:0] a, input bit clr, input bit e_en,
                     input logic [7:0] e_code, input logic [7:0] e_asc,
                     input logic [7:0] e_cnt, input bit e_rdy);
    vec_t x;
    x.r = r; x.v = v; x.b = b; x.code = c; x.asc = a; x.clr = clr;
    x.e_en = e_en; x.e_code = e_code; x.e_asc = e_asc; x.e_cnt = e_cnt; x.e_rdy = e_rdy;
    vt.push_back(x);
  endtask

  logic [7:0] pool[4] = '{8'h1C, 8'h32, 8'h1B, 8'h23};

  initial begin
    drive(1, 0, 0, 8'h00, 8'h00, 0);

    //   r v b code   asc    clr | en code   asc    cnt    rdy
    add(1, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 8'h00, 8'h00, 1);
    add(0, 1, 0, 8'h1C, 8'h61, 0,  1, 8'h1C, 8'h61, 8'h01, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1C, 8'h61, 8'h01, 1);
    add(0, 1, 0, 8'h1C, 8'h61, 0,  1, 8'h1C, 8'h61, 8'h01, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1C, 8'h61, 8'h01, 1);
    add(0, 1, 0, 8'h1C, 8'h61, 0,  1, 8'h1C, 8'h61, 8'h01, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1C, 8'h61, 8'h01, 1);
    add(0, 1, 0, 8'h1C, 8'h61, 0,  1, 8'h1C, 8'h61, 8'h01, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1C, 8'h61, 8'h01, 1);
    add(0, 1, 1, 8'h1C, 8'h00, 0,  1, 8'h1C, 8'h61, 8'h01, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1C, 8'h61, 8'h01, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1C, 8'h61, 8'h01, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1C, 8'h61, 8'h01, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0,  0, 8'h1C, 8'h61, 8'h01, 1);
    add(0, 1, 0, 8'h1C, 8'h61, 0,  1, 8'h1C, 8'h61, 8'h02, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1C, 8'h61, 8'h02, 1);
    add(0, 1, 0, 8'h32, 8'h64, 0,  1, 8'h32, 8'h64, 8'h03, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h32, 8'h64, 8'h03, 1);
    add(0, 1, 1, 8'h1C, 8'h00, 0,  1, 8'h32, 8'h64, 8'h03, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h32, 8'h64, 8'h03, 1);
    add(0, 1, 0, 8'h1B, 8'h62, 1,  1, 8'h1B, 8'h62, 8'h00, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1B, 8'h62, 8'h00, 1);
    add(0, 1, 1, 8'h1B, 8'h00, 0,  1, 8'h1B, 8'h62, 8'h00, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1B, 8'h62, 8'h00, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0,  1, 8'h1B, 8'h62, 8'h00, 1);
    add(1, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 8'h00, 8'h00, 1);
    add(1, 1, 0, 8'h1C, 8'h61, 0,  0, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 8'h00, 8'h00, 1);
    add(0, 1, 1, 8'h1C, 8'h00, 0,  0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 8'h00, 8'h00, 1);
    add(0, 1, 0, 8'h2A, 8'h7A, 0,  1, 8'h2A, 8'h7A, 8'h01, 0);
    add(0, 1, 0, 8'h2A, 8'h7A, 0,  1, 8'h2A, 8'h7A, 8'h01, 1);
    add(0, 1, 0, 8'h2A, 8'h7A, 0,  1, 8'h2A, 8'h7A, 8'h01, 0);

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].v, vt[i].b, vt[i].code, vt[i].asc, vt[i].clr);
      cycle();
      check($sformatf("row%0d en", i),    en4,   8'(vt[i].e_en));
      check($sformatf("row%0d code", i),  code4, vt[i].e_code);
      check($sformatf("row%0d ascii", i), asc4,  vt[i].e_asc);
      check($sformatf("row%0d count", i), cnt4,  vt[i].e_cnt);
      check($sformatf("row%0d ready", i), rdy4,  8'(vt[i].e_rdy));
    end

    // Zero hold time: release blanks on the very next cycle.
    drive(1, 0, 0, 8'h00, 8'h00, 0); cycle();
    drive(0, 1, 0, 8'h45, 8'h30, 0); cycle();
    check("h0 make en", en0, 8'h01);
    check("h0 make cnt", cnt0, 8'h01);
    drive(0, 0, 0, 8'h00, 8'h00, 0); cycle();
    drive(0, 1, 1, 8'h45, 8'h00, 0); cycle();
    check("h0 break en", en0, 8'h00);
    check("h0 break code", code0, 8'h45);
    check("h0 break rdy", rdy0, 8'h00);
    check("h4 break en", en4, 8'h01);
    drive(0, 0, 0, 8'h00, 8'h00, 0); cycle();
    check("h0 idle en", en0, 8'h00);

    // Count sweep: 100 distinct presses, through 09->10 and 99->00.
    drive(1, 0, 0, 8'h00, 8'h00, 0); cycle();
    for (int i = 1; i <= 100; i++) begin
      drive(0, 1, 0, (i % 2) ? 8'h21 : 8'h22, 8'(i), 0); cycle();
      check($sformatf("sweep%0d count", i), cnt4, to_bcd(i % 100));
      check($sformatf("sweep%0d units", i), 8'(cnt4[3:0] <= 4'd9), 8'h01);
      check($sformatf("sweep%0d tens", i),  8'(cnt4[7:4] <= 4'd9), 8'h01);
      drive(0, 0, 0, 8'h00, 8'h00, 0); cycle();
    end

    // Randomized run against the model.
    drive(1, 0, 0, 8'h00, 8'h00, 0); cycle();
    for (int n = 0; n < 3000; n++) begin
      bit hold_inputs;
      hold_inputs = evt_valid && !m_rdy[0];
      rst = ($urandom_range(0, 99) == 0);
      cnt_clr = ($urandom_range(0, 15) == 0);
      if (!hold_inputs) begin
        evt_valid = $urandom_range(0, 1) == 1;
        evt_break = $urandom_range(0, 9) < 4;
        evt_code  = pool[$urandom_range(0, 3)];
        evt_ascii = 8'($urandom);
      end
      cycle();
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
